// File: rtl/axi_ext_slave_gate_if.sv
// Valid/ready handshake bundle gated by axi_ext_slave_gate.
// The slave modport is the gate's view and the master modport is the view of the surrounding system.
interface axi_ext_slave_gate_if;
  logic S_AXI_AWVALID;
  logic S_AXI_AWREADY;
  logic M_AXI_AWVALID;
  logic M_AXI_AWREADY;
  logic S_AXI_WVALID;
  logic S_AXI_WLAST;
  logic S_AXI_WREADY;
  logic M_AXI_WVALID;
  logic M_AXI_WREADY;
  logic S_AXI_ARVALID;
  logic S_AXI_ARREADY;
  logic M_AXI_ARVALID;
  logic M_AXI_ARREADY;
  logic M_AXI_BVALID;
  logic S_AXI_BREADY;
  logic M_AXI_RVALID;
  logic M_AXI_RLAST;
  logic S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWVALID, M_AXI_AWREADY,
    output M_AXI_AWVALID, S_AXI_AWREADY,
    input  S_AXI_WVALID, S_AXI_WLAST, M_AXI_WREADY,
    output M_AXI_WVALID, S_AXI_WREADY,
    input  S_AXI_ARVALID, M_AXI_ARREADY,
    output M_AXI_ARVALID, S_AXI_ARREADY,
    input  M_AXI_BVALID, S_AXI_BREADY,
    input  M_AXI_RVALID, M_AXI_RLAST, S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWVALID, M_AXI_AWREADY,
    input  M_AXI_AWVALID, S_AXI_AWREADY,
    output S_AXI_WVALID, S_AXI_WLAST, M_AXI_WREADY,
    input  M_AXI_WVALID, S_AXI_WREADY,
    output S_AXI_ARVALID, M_AXI_ARREADY,
    input  M_AXI_ARVALID, S_AXI_ARREADY,
    output M_AXI_BVALID, S_AXI_BREADY,
    output M_AXI_RVALID, M_AXI_RLAST, S_AXI_RREADY
  );
endinterface

// File: rtl/axi_ext_slave_gate.sv
// Outstanding-transaction limiter and quiesce gate for an external AXI slave.
// Only the valid/ready pairs are gated; payload, B and R channels bypass this block.
module axi_ext_slave_gate #(
  parameter int C_MAX_OUTSTANDING = 8,
  parameter int C_CNT_WIDTH       = 4
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  axi_ext_slave_gate_if.slave    bus,
  input  logic                   QUIESCE_REQ,
  output logic                   QUIESCE_ACK,
  output logic [C_CNT_WIDTH-1:0] WR_OUTSTANDING,
  output logic [C_CNT_WIDTH-1:0] RD_OUTSTANDING,
  output logic                   CNT_ERR
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_QUIESCED} state_t;

  localparam logic [C_CNT_WIDTH-1:0] MAX_CNT = C_CNT_WIDTH'(C_MAX_OUTSTANDING);
  localparam logic [C_CNT_WIDTH-1:0] ONE     = C_CNT_WIDTH'(1);

  state_t state_reg, state_next;

  // Counter index 0: write bursts, 1: read bursts, 2: write-data credit.
  logic [2:0] cnt_inc, cnt_dec, cnt_err_hit, cnt_zero;
  logic       cnt_err_reg;

  // Address channel index 0: AW, 1: AR.
  logic [1:0] addr_s_valid, addr_m_ready, addr_m_valid, addr_s_ready;
  logic [1:0] addr_en, addr_hs, addr_hold_reg, below_max;

  logic w_en, wlhs, bhs, rlhs;

  assign addr_s_valid = {bus.S_AXI_ARVALID, bus.S_AXI_AWVALID};
  assign addr_m_ready = {bus.M_AXI_ARREADY, bus.M_AXI_AWREADY};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_addr
      // A hold keeps an already-presented valid alive through throttling or drain.
      assign addr_en[gi]      = ((state_reg == ST_RUN) & below_max[gi]) | addr_hold_reg[gi];
      assign addr_m_valid[gi] = addr_s_valid[gi] & addr_en[gi];
      assign addr_s_ready[gi] = addr_m_ready[gi] & addr_en[gi];
      assign addr_hs[gi]      = addr_m_valid[gi] & addr_m_ready[gi];

      always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
          addr_hold_reg[gi] <= 1'b0;
        end else if (addr_hs[gi]) begin
          addr_hold_reg[gi] <= 1'b0;
        end else if (addr_m_valid[gi]) begin
          addr_hold_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  assign bus.M_AXI_AWVALID = addr_m_valid[0];
  assign bus.S_AXI_AWREADY = addr_s_ready[0];
  assign bus.M_AXI_ARVALID = addr_m_valid[1];
  assign bus.S_AXI_ARREADY = addr_s_ready[1];

  assign w_en             = ~cnt_zero[2];
  assign bus.M_AXI_WVALID = bus.S_AXI_WVALID & w_en;
  assign bus.S_AXI_WREADY = bus.M_AXI_WREADY & w_en;

  assign wlhs = bus.M_AXI_WVALID & bus.M_AXI_WREADY & bus.S_AXI_WLAST;
  assign bhs  = bus.M_AXI_BVALID & bus.S_AXI_BREADY;
  assign rlhs = bus.M_AXI_RVALID & bus.S_AXI_RREADY & bus.M_AXI_RLAST;

  assign cnt_inc = {addr_hs[0], addr_hs[1], addr_hs[0]};
  assign cnt_dec = {wlhs, rlhs, bhs};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      logic [C_CNT_WIDTH-1:0] cnt_reg;
      logic                   step_up, step_dn;

      assign step_up         = cnt_inc[gi] & ~cnt_dec[gi];
      assign step_dn         = cnt_dec[gi] & ~cnt_inc[gi];
      assign cnt_zero[gi]    = (cnt_reg == '0);
      // Underflow is clamped at zero and reported through the sticky error flag.
      assign cnt_err_hit[gi] = step_dn & cnt_zero[gi];

      always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
          cnt_reg <= '0;
        end else if (step_up) begin
          cnt_reg <= cnt_reg + ONE;
        end else if (step_dn && !cnt_zero[gi]) begin
          cnt_reg <= cnt_reg - ONE;
        end
      end
    end
  endgenerate

  assign below_max = {(g_cnt[1].cnt_reg < MAX_CNT), (g_cnt[0].cnt_reg < MAX_CNT)};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt_err_reg <= 1'b0;
    end else if (|cnt_err_hit) begin
      cnt_err_reg <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN: begin
        if (QUIESCE_REQ) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!QUIESCE_REQ) begin
          state_next = ST_RUN;
        end else if ((&cnt_zero) && (addr_hold_reg == 2'b00)) begin
          state_next = ST_QUIESCED;
        end
      end
      ST_QUIESCED: begin
        if (!QUIESCE_REQ) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  assign QUIESCE_ACK    = (state_reg == ST_QUIESCED);
  assign WR_OUTSTANDING = g_cnt[0].cnt_reg;
  assign RD_OUTSTANDING = g_cnt[1].cnt_reg;
  assign CNT_ERR        = cnt_err_reg;

endmodule

// File: tb/tb_axi_ext_slave_gate.sv
// Directed scenarios plus randomized traffic checked against a cycle-level
// model of the gating rules (counts, hold flags, quiesce state).
module tb_axi_ext_slave_gate;
  localparam int MAX = 8;
  localparam int CW  = 4;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic          QUIESCE_REQ = 1'b0;
  logic          QUIESCE_ACK;
  logic [CW-1:0] WR_OUTSTANDING, RD_OUTSTANDING;
  logic          CNT_ERR;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: outstanding writes, reads, write-data credit, sticky error,
  // address holds, and phase (0 run, 1 drain, 2 quiesced).
  int m_wr, m_rd, m_cr, m_state;
  bit m_err, m_awh, m_arh;

  axi_ext_slave_gate_if bus ();

  axi_ext_slave_gate #(.C_MAX_OUTSTANDING(MAX), .C_CNT_WIDTH(CW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .bus(bus),
    .QUIESCE_REQ(QUIESCE_REQ), .QUIESCE_ACK(QUIESCE_ACK),
    .WR_OUTSTANDING(WR_OUTSTANDING), .RD_OUTSTANDING(RD_OUTSTANDING),
    .CNT_ERR(CNT_ERR)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_cr = 0; m_state = 0;
    m_err = 0; m_awh = 0; m_arh = 0;
  endtask

  function automatic int step(int c, bit inc, bit dec);
    if (inc && !dec) return c + 1;
    if (dec && !inc && c > 0) return c - 1;
    return c;
  endfunction

  // Advance one clock edge, updating the model from the inputs held during the cycle.
  task automatic tick();
    bit aw_en, ar_en, awv, arv, awhs, arhs, wlhs, bhs, rlhs, idle;
    int ns;
    aw_en = (m_state == 0 && m_wr < MAX) || m_awh;
    ar_en = (m_state == 0 && m_rd < MAX) || m_arh;
    awv   = bus.S_AXI_AWVALID && aw_en;
    arv   = bus.S_AXI_ARVALID && ar_en;
    awhs  = awv && bus.M_AXI_AWREADY;
    arhs  = arv && bus.M_AXI_ARREADY;
    wlhs  = bus.S_AXI_WVALID && (m_cr != 0) && bus.M_AXI_WREADY && bus.S_AXI_WLAST;
    bhs   = bus.M_AXI_BVALID && bus.S_AXI_BREADY;
    rlhs  = bus.M_AXI_RVALID && bus.S_AXI_RREADY && bus.M_AXI_RLAST;
    idle  = (m_wr == 0) && (m_rd == 0) && (m_cr == 0) && !m_awh && !m_arh;
    if (m_state == 0)      ns = QUIESCE_REQ ? 1 : 0;
    else if (m_state == 1) ns = !QUIESCE_REQ ? 0 : (idle ? 2 : 1);
    else                   ns = QUIESCE_REQ ? 2 : 0;
    @(posedge ACLK);
    if (!ARESETN) begin
      model_reset();
    end else begin
      if ((bhs && !awhs && m_wr == 0) || (rlhs && !arhs && m_rd == 0) || (wlhs && !awhs && m_cr == 0))
        m_err = 1;
      m_wr = step(m_wr, awhs, bhs);
      m_rd = step(m_rd, arhs, rlhs);
      m_cr = step(m_cr, awhs, wlhs);
      m_awh = awhs ? 1'b0 : (awv ? 1'b1 : m_awh);
      m_arh = arhs ? 1'b0 : (arv ? 1'b1 : m_arh);
      m_state = ns;
    end
    #1;
  endtask

  task automatic clear_inputs();
    bus.S_AXI_AWVALID = 0; bus.M_AXI_AWREADY = 0;
    bus.S_AXI_WVALID = 0; bus.S_AXI_WLAST = 0; bus.M_AXI_WREADY = 0;
    bus.S_AXI_ARVALID = 0; bus.M_AXI_ARREADY = 0;
    bus.M_AXI_BVALID = 0; bus.S_AXI_BREADY = 0;
    bus.M_AXI_RVALID = 0; bus.M_AXI_RLAST = 0; bus.S_AXI_RREADY = 0;
    QUIESCE_REQ = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    ARESETN = 0;
    @(posedge ACLK);
    @(posedge ACLK);
    #1;
    ARESETN = 1;
    model_reset();
  endtask

  task automatic test_reset();
    clear_inputs();
    ARESETN = 0;
    bus.S_AXI_WVALID = 1; bus.M_AXI_WREADY = 1;
    #1;
    n_tests++;
    if ({QUIESCE_ACK, CNT_ERR, WR_OUTSTANDING, RD_OUTSTANDING, bus.M_AXI_WVALID, bus.S_AXI_WREADY} !== 12'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ack=%b err=%b wr=%0d rd=%0d wv=%b wr_rdy=%b expected all 0",
               QUIESCE_ACK, CNT_ERR, WR_OUTSTANDING, RD_OUTSTANDING, bus.M_AXI_WVALID, bus.S_AXI_WREADY);
    end
    do_reset();
    bus.S_AXI_AWVALID = 1; bus.S_AXI_ARVALID = 1;
    #1;
    n_tests++;
    if ({bus.M_AXI_AWVALID, bus.M_AXI_ARVALID} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_run_state: got awv=%b arv=%b expected 1 1", bus.M_AXI_AWVALID, bus.M_AXI_ARVALID);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_throttle();
    do_reset();
    bus.M_AXI_AWREADY = 1; bus.S_AXI_AWVALID = 1;
    for (int i = 0; i < MAX; i++) begin
      #1;
      n_tests++;
      if (bus.M_AXI_AWVALID !== 1'b1) begin
        n_fail++;
        $display("FAIL throttle_accept_%0d: got awv=%b expected 1", i, bus.M_AXI_AWVALID);
      end
      tick();
    end
    #1;
    n_tests++;
    if (WR_OUTSTANDING !== 4'd8 || bus.M_AXI_AWVALID !== 1'b0 || bus.S_AXI_AWREADY !== 1'b0) begin
      n_fail++;
      $display("FAIL throttle_full: got wr=%0d awv=%b awr=%b expected 8 0 0",
               WR_OUTSTANDING, bus.M_AXI_AWVALID, bus.S_AXI_AWREADY);
    end
    bus.M_AXI_BVALID = 1; bus.S_AXI_BREADY = 1;
    #1;
    n_tests++;
    if (bus.M_AXI_AWVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL throttle_blocked_during_b: got awv=%b expected 0", bus.M_AXI_AWVALID);
    end
    tick();
    bus.M_AXI_BVALID = 0;
    #1;
    n_tests++;
    if (WR_OUTSTANDING !== 4'd7 || bus.M_AXI_AWVALID !== 1'b1) begin
      n_fail++;
      $display("FAIL throttle_released: got wr=%0d awv=%b expected 7 1", WR_OUTSTANDING, bus.M_AXI_AWVALID);
    end
    tick();
    bus.S_AXI_AWVALID = 0;
    #1;
    n_tests++;
    if (WR_OUTSTANDING !== 4'd8) begin
      n_fail++;
      $display("FAIL throttle_ninth: got wr=%0d expected 8", WR_OUTSTANDING);
    end
    $display("[TB] test_throttle done");
  endtask

  task automatic test_drain();
    do_reset();
    bus.M_AXI_ARREADY = 1; bus.S_AXI_ARVALID = 1;
    tick(); tick();
    bus.S_AXI_ARVALID = 0;
    QUIESCE_REQ = 1;
    tick();
    bus.S_AXI_ARVALID = 1;
    #1;
    n_tests++;
    if (RD_OUTSTANDING !== 4'd2 || bus.M_AXI_ARVALID !== 1'b0 || bus.S_AXI_ARREADY !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_ar_blocked: got rd=%0d arv=%b arr=%b expected 2 0 0",
               RD_OUTSTANDING, bus.M_AXI_ARVALID, bus.S_AXI_ARREADY);
    end
    tick();
    bus.M_AXI_RVALID = 1; bus.S_AXI_RREADY = 1; bus.M_AXI_RLAST = 1;
    tick(); tick();
    bus.M_AXI_RVALID = 0;
    #1;
    n_tests++;
    if (RD_OUTSTANDING !== 4'd0 || QUIESCE_ACK !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_pre_ack: got rd=%0d ack=%b expected 0 0", RD_OUTSTANDING, QUIESCE_ACK);
    end
    tick();
    n_tests++;
    if (QUIESCE_ACK !== 1'b1 || bus.M_AXI_ARVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_ack: got ack=%b arv=%b expected 1 0", QUIESCE_ACK, bus.M_AXI_ARVALID);
    end
    QUIESCE_REQ = 0;
    #1;
    n_tests++;
    if (QUIESCE_ACK !== 1'b1 || bus.M_AXI_ARVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_registered_release: got ack=%b arv=%b expected 1 0", QUIESCE_ACK, bus.M_AXI_ARVALID);
    end
    tick();
    n_tests++;
    if (QUIESCE_ACK !== 1'b0 || bus.M_AXI_ARVALID !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_resume: got ack=%b arv=%b expected 0 1", QUIESCE_ACK, bus.M_AXI_ARVALID);
    end
    $display("[TB] test_drain done");
  endtask

  task automatic test_hold();
    do_reset();
    bus.S_AXI_AWVALID = 1; bus.M_AXI_AWREADY = 0;
    tick();
    QUIESCE_REQ = 1;
    tick(); tick(); tick();
    n_tests++;
    if (bus.M_AXI_AWVALID !== 1'b1 || QUIESCE_ACK !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_kept: got awv=%b ack=%b expected 1 0", bus.M_AXI_AWVALID, QUIESCE_ACK);
    end
    bus.M_AXI_AWREADY = 1;
    #1;
    n_tests++;
    if (bus.S_AXI_AWREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_ready: got awr=%b expected 1", bus.S_AXI_AWREADY);
    end
    tick();
    n_tests++;
    if (bus.M_AXI_AWVALID !== 1'b0 || WR_OUTSTANDING !== 4'd1) begin
      n_fail++;
      $display("FAIL hold_released: got awv=%b wr=%0d expected 0 1", bus.M_AXI_AWVALID, WR_OUTSTANDING);
    end
    bus.S_AXI_AWVALID = 0;
    bus.S_AXI_WVALID = 1; bus.M_AXI_WREADY = 1; bus.S_AXI_WLAST = 1;
    tick();
    bus.S_AXI_WVALID = 0;
    tick(); tick();
    n_tests++;
    if (QUIESCE_ACK !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_wait_b: got ack=%b expected 0", QUIESCE_ACK);
    end
    bus.M_AXI_BVALID = 1; bus.S_AXI_BREADY = 1;
    tick();
    bus.M_AXI_BVALID = 0;
    n_tests++;
    if (QUIESCE_ACK !== 1'b0 || WR_OUTSTANDING !== 4'd0) begin
      n_fail++;
      $display("FAIL hold_b_done: got ack=%b wr=%0d expected 0 0", QUIESCE_ACK, WR_OUTSTANDING);
    end
    tick();
    n_tests++;
    if (QUIESCE_ACK !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_ack: got ack=%b expected 1", QUIESCE_ACK);
    end
    $display("[TB] test_hold done");
  endtask

  task automatic test_w_before_aw();
    do_reset();
    bus.S_AXI_WVALID = 1; bus.M_AXI_WREADY = 1; bus.S_AXI_WLAST = 0;
    #1;
    n_tests++;
    if (bus.M_AXI_WVALID !== 1'b0 || bus.S_AXI_WREADY !== 1'b0) begin
      n_fail++;
      $display("FAIL w_stalled: got wv=%b wr=%b expected 0 0", bus.M_AXI_WVALID, bus.S_AXI_WREADY);
    end
    tick();
    bus.S_AXI_AWVALID = 1; bus.M_AXI_AWREADY = 1;
    #1;
    n_tests++;
    if (bus.M_AXI_WVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL w_same_cycle_aw: got wv=%b expected 0", bus.M_AXI_WVALID);
    end
    tick();
    bus.S_AXI_AWVALID = 0;
    #1;
    n_tests++;
    if (bus.M_AXI_WVALID !== 1'b1 || bus.S_AXI_WREADY !== 1'b1) begin
      n_fail++;
      $display("FAIL w_pass: got wv=%b wr=%b expected 1 1", bus.M_AXI_WVALID, bus.S_AXI_WREADY);
    end
    tick();
    bus.S_AXI_WLAST = 1;
    #1;
    n_tests++;
    if (bus.M_AXI_WVALID !== 1'b1) begin
      n_fail++;
      $display("FAIL w_last_pass: got wv=%b expected 1", bus.M_AXI_WVALID);
    end
    tick();
    n_tests++;
    if (bus.M_AXI_WVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL w_credit_zero: got wv=%b expected 0", bus.M_AXI_WVALID);
    end
    $display("[TB] test_w_before_aw done");
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.S_AXI_AWVALID = 1; bus.M_AXI_AWREADY = 1;
    tick(); tick(); tick();
    bus.M_AXI_BVALID = 1; bus.S_AXI_BREADY = 1;
    tick();
    bus.S_AXI_AWVALID = 0;
    n_tests++;
    if (WR_OUTSTANDING !== 4'd3) begin
      n_fail++;
      $display("FAIL simul_aw_b: got wr=%0d expected 3", WR_OUTSTANDING);
    end
    tick(); tick(); tick();
    n_tests++;
    if (WR_OUTSTANDING !== 4'd0 || CNT_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_drained: got wr=%0d err=%b expected 0 0", WR_OUTSTANDING, CNT_ERR);
    end
    tick();
    bus.M_AXI_BVALID = 0;
    n_tests++;
    if (WR_OUTSTANDING !== 4'd0 || CNT_ERR !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_underflow: got wr=%0d err=%b expected 0 1", WR_OUTSTANDING, CNT_ERR);
    end
    tick(); tick();
    n_tests++;
    if (CNT_ERR !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_err_sticky: got err=%b expected 1", CNT_ERR);
    end
    $display("[TB] test_simultaneous done");
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.M_AXI_ARREADY = 1; bus.S_AXI_ARVALID = 1;
    bus.M_AXI_AWREADY = 1; bus.S_AXI_AWVALID = 1;
    tick(); tick();
    bus.S_AXI_ARVALID = 0; bus.S_AXI_AWVALID = 0;
    bus.M_AXI_RVALID = 1; bus.S_AXI_RREADY = 1; bus.M_AXI_RLAST = 0;
    QUIESCE_REQ = 1;
    tick();
    bus.S_AXI_WVALID = 1; bus.M_AXI_WREADY = 1;
    #1;
    n_tests++;
    if (RD_OUTSTANDING !== 4'd2 || WR_OUTSTANDING !== 4'd2 || bus.M_AXI_WVALID !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre: got rd=%0d wr=%0d wv=%b expected 2 2 1",
               RD_OUTSTANDING, WR_OUTSTANDING, bus.M_AXI_WVALID);
    end
    ARESETN = 0;
    #1;
    n_tests++;
    if ({QUIESCE_ACK, CNT_ERR, WR_OUTSTANDING, RD_OUTSTANDING, bus.M_AXI_WVALID, bus.S_AXI_WREADY} !== 12'b0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got ack=%b err=%b wr=%0d rd=%0d wv=%b wr_rdy=%b expected all 0",
               QUIESCE_ACK, CNT_ERR, WR_OUTSTANDING, RD_OUTSTANDING, bus.M_AXI_WVALID, bus.S_AXI_WREADY);
    end
    model_reset();
    clear_inputs();
    #1;
    ARESETN = 1;
    bus.S_AXI_ARVALID = 1;
    #1;
    n_tests++;
    if (bus.M_AXI_ARVALID !== 1'b1) begin
      n_fail++;
      $display("FAIL async_resume: got arv=%b expected 1", bus.M_AXI_ARVALID);
    end
    tick();
    $display("[TB] test_async_reset done");
  endtask

  task automatic test_random();
    bit aw_en, ar_en, w_en;
    logic [15:0] got, exp;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.S_AXI_AWVALID = ($urandom_range(0, 2) == 0);
      bus.M_AXI_AWREADY = ($urandom_range(0, 1) == 0);
      bus.S_AXI_WVALID  = ($urandom_range(0, 1) == 0);
      bus.S_AXI_WLAST   = ($urandom_range(0, 1) == 0);
      bus.M_AXI_WREADY  = ($urandom_range(0, 1) == 0);
      bus.S_AXI_ARVALID = ($urandom_range(0, 2) == 0);
      bus.M_AXI_ARREADY = ($urandom_range(0, 1) == 0);
      // Write responses only for writes whose data has finished.
      bus.M_AXI_BVALID  = (m_wr > m_cr) && ($urandom_range(0, 2) == 0);
      bus.S_AXI_BREADY  = ($urandom_range(0, 3) != 0);
      bus.M_AXI_RVALID  = ($urandom_range(0, 2) == 0);
      bus.M_AXI_RLAST   = ($urandom_range(0, 1) == 0);
      bus.S_AXI_RREADY  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) QUIESCE_REQ = ~QUIESCE_REQ;
      #1;
      aw_en = (m_state == 0 && m_wr < MAX) || m_awh;
      ar_en = (m_state == 0 && m_rd < MAX) || m_arh;
      w_en  = (m_cr != 0);
      exp = {bus.S_AXI_AWVALID & aw_en, bus.M_AXI_AWREADY & aw_en,
             bus.S_AXI_ARVALID & ar_en, bus.M_AXI_ARREADY & ar_en,
             bus.S_AXI_WVALID & w_en, bus.M_AXI_WREADY & w_en,
             1'(m_state == 2), m_err, 4'(m_wr), 4'(m_rd)};
      got = {bus.M_AXI_AWVALID, bus.S_AXI_AWREADY, bus.M_AXI_ARVALID, bus.S_AXI_ARREADY,
             bus.M_AXI_WVALID, bus.S_AXI_WREADY, QUIESCE_ACK, CNT_ERR, WR_OUTSTANDING, RD_OUTSTANDING};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: got %b expected %b (awv awr arv arr wv wr ack err wr_cnt rd_cnt)",
                 i, got, exp);
      end
      tick();
    end
    $display("[TB] test_random done");
  endtask

  initial begin
    test_reset();
    test_throttle();
    test_drain();
    test_hold();
    test_w_before_aw();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
